// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR stream checker: seeds a mirror register from the received
// stream, verifies it against predictions, then flags bit errors while locked.
module lfsr_checker #(
    parameter int               WIDTH          = 16,
    parameter logic [WIDTH-1:0] FEEDBACK       = WIDTH'(16'b0000_0000_0010_1101),
    parameter int               LOCK_COUNT     = 32,
    parameter int               WINDOW         = 64,
    parameter int               LOSS_THRESHOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             err_clear,
    output logic             locked,
    output logic             bit_error,
    output logic [15:0]      error_count,
    output logic [WIDTH-1:0] state
);

    localparam int SCW = $clog2(WIDTH + 1);
    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int WCW = $clog2(WINDOW + 1);
    localparam int ECW = $clog2(LOSS_THRESHOLD + 1);

    localparam logic [SCW-1:0] SEED_LAST  = SCW'(WIDTH - 1);
    localparam logic [MCW-1:0] MATCH_LAST = MCW'(LOCK_COUNT - 1);
    localparam logic [WCW-1:0] WIN_LAST   = WCW'(WINDOW - 1);
    localparam logic [ECW-1:0] ERR_LIMIT  = ECW'(LOSS_THRESHOLD);

    typedef enum logic [1:0] {
        S_SEED   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [SCW-1:0]   seed_cnt_q, seed_cnt_d;
    logic [MCW-1:0]   match_cnt_q, match_cnt_d;
    logic [WCW-1:0]   win_cnt_q, win_cnt_d;
    logic [ECW-1:0]   win_err_q, win_err_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             locked_q, locked_d;
    logic             bit_err_q, bit_err_d;

    logic             predicted;
    logic             new_err;
    logic [ECW-1:0]   err_sum;
    logic [15:0]      cnt_base;

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        new_err     = 1'b0;
        err_sum     = '0;
        predicted   = ^(state_q & FEEDBACK);

        if (in_valid) begin
            case (fsm_q)
                S_SEED: begin
                    state_d = {in_bit, state_q[WIDTH-1:1]};
                    if (seed_cnt_q == SEED_LAST) begin
                        // An all-zero seed would lock onto the LFSR's stuck state, so reseed instead.
                        seed_cnt_d = '0;
                        if (state_d != '0) begin
                            fsm_d = S_VERIFY;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + SCW'(1);
                    end
                end
                S_VERIFY: begin
                    state_d = {in_bit, state_q[WIDTH-1:1]};
                    if (in_bit == predicted) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            fsm_d       = S_LOCKED;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MCW'(1);
                        end
                    end else begin
                        fsm_d       = S_SEED;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    // Free-run on our own prediction so line errors never pollute the mirror.
                    state_d = {predicted, state_q[WIDTH-1:1]};
                    new_err = (in_bit != predicted);
                    err_sum = win_err_q + ECW'(new_err);
                    if (err_sum == ERR_LIMIT) begin
                        fsm_d       = S_SEED;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                        win_cnt_d   = '0;
                        win_err_d   = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WCW'(1);
                        win_err_d = err_sum;
                    end
                end
                default: begin
                    fsm_d = S_SEED;
                end
            endcase
        end

        // Clear takes effect before a coincident increment.
        cnt_base  = err_clear ? 16'd0 : err_cnt_q;
        err_cnt_d = (new_err && (cnt_base != 16'hFFFF)) ? cnt_base + 16'd1 : cnt_base;
        bit_err_d = new_err;
        locked_d  = (fsm_d == S_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_SEED;
            state_q     <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
        end
    end

    assign locked      = locked_q;
    assign bit_error   = bit_err_q;
    assign error_count = err_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scenario bench for lfsr_checker: reference generator drives the stream, expected
// outputs are queued per driven bit and compared one clock later.
`timescale 1ns/1ps
module tb_lfsr_checker;

    localparam logic [15:0] FB = 16'b0000_0000_0010_1101;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_bit, err_clear;
    logic        locked, bit_error;
    logic [15:0] error_count;
    logic [15:0] state;

    logic        v2, b2, c2;
    logic        lk2, be2;
    logic [15:0] cnt2;
    logic [15:0] st2;

    typedef struct packed {
        logic        lk;
        logic        be;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          vecs = 0;
    int          miss = 0;
    logic [15:0] g;

    lfsr_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .err_clear(err_clear),
        .locked(locked), .bit_error(bit_error), .error_count(error_count), .state(state)
    );

    // Second instance whose loss threshold can never be reached, for saturating the counter.
    lfsr_checker #(.LOSS_THRESHOLD(65)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(v2), .in_bit(b2), .err_clear(c2),
        .locked(lk2), .bit_error(be2), .error_count(cnt2), .state(st2)
    );

    always #5 clk = ~clk;

    task automatic gen_next(output logic b);
        b = ^(g & FB);
        g = {b, g[15:1]};
    endtask

    task automatic drive(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid  = v;
        in_bit    = b;
        err_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0; err_clear = 1'b0;
        v2 = 1'b0; b2 = 1'b0; c2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic acquire();
        logic b;
        g = 16'hACE1;
        for (int i = 0; i < 48; i++) begin
            gen_next(b);
            drive(1'b1, b, 1'b0);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; err_clear = 1'b0;
        v2 = 1'b0; b2 = 1'b0; c2 = 1'b0;
        #3 rst = 1'b1;
        #1;
        sb.push_back(exp_t'{lk: 1'b0, be: 1'b0, cnt: 16'd0});
        e = sb.pop_front();
        vecs++;
        if ({locked, bit_error, error_count} !== e || state !== 16'd0) begin
            miss++;
            $display("FAIL reset: got lk=%b be=%b cnt=%h st=%h, want lk=%b be=%b cnt=%h st=0000",
                     locked, bit_error, error_count, state, e.lk, e.be, e.cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock_acquire();
        exp_t e;
        logic b;
        do_reset();
        g = 16'hACE1;
        for (int i = 0; i < 60; i++) begin
            gen_next(b);
            sb.push_back(exp_t'{lk: (i >= 47), be: 1'b0, cnt: 16'd0});
            drive(1'b1, b, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({locked, bit_error, error_count} !== e) begin
                miss++;
                $display("FAIL lock_acquire[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, locked, bit_error, error_count, e.lk, e.be, e.cnt);
            end
        end
        vecs++;
        if (state !== g) begin
            miss++;
            $display("FAIL lock_state: got %h, want %h", state, g);
        end
    endtask

    task automatic test_single_error();
        exp_t e;
        logic b;
        do_reset();
        acquire();
        for (int i = 0; i < 40; i++) begin
            gen_next(b);
            sb.push_back(exp_t'{lk: 1'b1, be: (i == 5), cnt: (i >= 5) ? 16'd1 : 16'd0});
            drive(1'b1, b ^ (i == 5), 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({locked, bit_error, error_count} !== e) begin
                miss++;
                $display("FAIL single_error[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, locked, bit_error, error_count, e.lk, e.be, e.cnt);
            end
        end
    endtask

    task automatic test_burst_loss();
        exp_t e;
        logic b;
        logic flip;
        int   nerr = 0;
        do_reset();
        acquire();
        for (int i = 0; i < 90; i++) begin
            gen_next(b);
            flip = (i == 3) || (i == 10) || (i == 20) || (i == 30);
            if (flip) nerr++;
            sb.push_back(exp_t'{lk: (i < 30) || (i >= 78), be: flip, cnt: 16'(nerr)});
            drive(1'b1, b ^ flip, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({locked, bit_error, error_count} !== e) begin
                miss++;
                $display("FAIL burst_loss[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, locked, bit_error, error_count, e.lk, e.be, e.cnt);
            end
        end
    endtask

    task automatic test_zero_stream();
        exp_t e;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            sb.push_back(exp_t'{lk: 1'b0, be: 1'b0, cnt: 16'd0});
            drive(1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({locked, bit_error, error_count} !== e) begin
                miss++;
                $display("FAIL zero_stream[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, locked, bit_error, error_count, e.lk, e.be, e.cnt);
            end
        end
    endtask

    task automatic test_verify_mismatch();
        exp_t e;
        logic b;
        do_reset();
        g = 16'hACE1;
        for (int i = 0; i < 80; i++) begin
            gen_next(b);
            sb.push_back(exp_t'{lk: (i >= 69), be: 1'b0, cnt: 16'd0});
            drive(1'b1, b ^ (i == 21), 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({locked, bit_error, error_count} !== e) begin
                miss++;
                $display("FAIL verify_mismatch[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, locked, bit_error, error_count, e.lk, e.be, e.cnt);
            end
        end
    endtask

    task automatic test_gaps_reset();
        exp_t e;
        logic b;
        logic v;
        int   nv = 0;
        do_reset();
        g = 16'hACE1;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 2) != 0);
            if (v) begin
                gen_next(b);
                nv++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            sb.push_back(exp_t'{lk: (nv >= 48), be: 1'b0, cnt: 16'd0});
            drive(v, b, 1'b0);
            e = sb.pop_front();
            vecs++;
            if ({locked, bit_error, error_count} !== e) begin
                miss++;
                $display("FAIL gaps[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, locked, bit_error, error_count, e.lk, e.be, e.cnt);
            end
            if (nv == 60) break;
        end
        vecs++;
        if (nv != 60 || locked !== 1'b1) begin
            miss++;
            $display("FAIL gaps_final: got nv=%0d lk=%b, want nv=60 lk=1", nv, locked);
        end
        // Reset mid-cycle, away from any clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vecs++;
        if (locked !== 1'b0 || bit_error !== 1'b0 || error_count !== 16'd0 || state !== 16'd0) begin
            miss++;
            $display("FAIL async_reset: got lk=%b be=%b cnt=%0d st=%h, want all zero",
                     locked, bit_error, error_count, state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_err_clear();
        exp_t e;
        logic b;
        int   val[6]  = '{1, 1, 1, 1, 0, 1};
        int   flp[6]  = '{0, 1, 1, 0, 0, 0};
        int   clr[6]  = '{0, 0, 1, 0, 1, 0};
        int   ecnt[6] = '{0, 1, 1, 1, 0, 0};
        do_reset();
        acquire();
        for (int i = 0; i < 6; i++) begin
            b = 1'b0;
            if (val[i] != 0) gen_next(b);
            sb.push_back(exp_t'{lk: 1'b1, be: (flp[i] != 0), cnt: 16'(ecnt[i])});
            drive(val[i] != 0, b ^ (flp[i] != 0), clr[i] != 0);
            e = sb.pop_front();
            vecs++;
            if ({locked, bit_error, error_count} !== e) begin
                miss++;
                $display("FAIL err_clear[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, locked, bit_error, error_count, e.lk, e.be, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic b;
        int   n;
        do_reset();
        g = 16'hACE1;
        for (int i = 0; i < 48 + 65538; i++) begin
            gen_next(b);
            n = (i >= 48) ? (i - 47) : 0;
            if (n > 65535) n = 65535;
            sb.push_back(exp_t'{lk: (i >= 47), be: (i >= 48), cnt: 16'(n)});
            @(negedge clk);
            v2 = 1'b1;
            b2 = b ^ (i >= 48);
            c2 = 1'b0;
            @(posedge clk);
            #1;
            e = sb.pop_front();
            vecs++;
            if ({lk2, be2, cnt2} !== e) begin
                miss++;
                $display("FAIL saturation[%0d]: got lk=%b be=%b cnt=%0d, want lk=%b be=%b cnt=%0d",
                         i, lk2, be2, cnt2, e.lk, e.be, e.cnt);
            end
        end
        @(negedge clk);
        v2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_burst_loss();
        test_zero_stream();
        test_verify_mismatch();
        test_gaps_reset();
        test_err_clear();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter: WIDTH, 16, LFSR register width in bits.
REQ-002 Parameter: FEEDBACK, 16'b0000_0000_0010_1101, tap mask, identical to the generator's tap mask.
REQ-003 Parameter: LOCK_COUNT, 32, consecutive correct predictions needed to declare lock.
REQ-004 Parameter: WINDOW, 64, length in valid bits of the loss-of-lock observation window.
REQ-005 Parameter: LOSS_THRESHOLD, 4, errors within one window that force loss of lock.
REQ-006 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 Port: rst  input  1  asynchronous, active-high reset.
REQ-008 Port: in_valid  input  1  in_bit is sampled on this cycle.
REQ-009 Port: in_bit  input  1  received bit; the stream is the feedback bit the generator shifts into its MSB each step.
REQ-010 Port: err_clear  input  1  synchronous clear of error_count.
REQ-011 Port: locked  output  1  checker is synchronised to the stream.
REQ-012 Port: bit_error  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-013 Port: error_count  output  16  saturating count of bit_error pulses.
REQ-014 Port: state  output  WIDTH  internal mirror register, for debug.

Function
REQ-015 Prediction: predicted = XOR-reduction of (state AND FEEDBACK); state update on a valid bit = {b, state[WIDTH-1:1]}, where b is the shifted-in bit.
REQ-016 Cycles without in_valid: no change to any register except err_clear handling.
REQ-017 FSM states: SEED, VERIFY, LOCKED.
REQ-018 SEED: b = in_bit; seed counter counts valid bits.
REQ-019 SEED exit: after WIDTH valid bits, go to VERIFY if the resulting state is nonzero.
REQ-020 SEED all-zero case: if the resulting state is all-zero, restart SEED with the counter at 0.
REQ-021 VERIFY: b = in_bit; compare in_bit against predicted.
REQ-022 VERIFY match: increment the match counter; on reaching LOCK_COUNT go to LOCKED.
REQ-023 VERIFY mismatch: go to SEED with seed and match counters at 0; the mismatched bit is still shifted into state.
REQ-024 LOCKED: b = predicted, so that received errors never corrupt state.
REQ-025 LOCKED mismatch: pulse bit_error on the following cycle and increment the window error count.
REQ-026 Window: the window counter counts valid bits 0..WINDOW-1 while LOCKED; on wrap, the window error count resets to 0.
REQ-027 Loss of lock: when the window error count reaches LOSS_THRESHOLD, go to SEED and clear all counters except error_count; the causing error still pulses bit_error and increments error_count.
REQ-028 locked = 1 exactly while the FSM is LOCKED; it is registered and rises on the cycle after the LOCK_COUNT-th matching bit.
REQ-029 error_count: increments by 1 per bit_error and saturates at 16'hFFFF.
REQ-030 err_clear with a simultaneous error: error_count becomes 1 (clear first, then increment).
REQ-031 err_clear affects only error_count; it does not change FSM state or any other counter.
REQ-032 Latency: all outputs are registered, one clk after the sampled valid bit; no combinational path from inputs to outputs.

Reset
REQ-033 rst asserted, at any time including mid-lock: immediately force FSM=SEED, state=0, all counters=0, locked=0, bit_error=0, error_count=0.
REQ-034 rst release: the first valid bit sampled after deassertion is seed bit 0.

Verification
REQ-035 Lock acquisition: feed the stream from a default-parameter generator initialised to 16'hACE1, one valid bit per cycle -> locked rises on the cycle after the 48th valid bit; error_count=0.
REQ-036 Single error: after lock, invert one bit -> bit_error high for exactly 1 cycle, error_count=1, locked stays 1, subsequent bits produce no errors.
REQ-037 Burst loss: after lock, invert 4 bits within 64 valid bits -> 4 bit_error pulses, error_count=4, locked falls after the 4th; the clean stream then re-locks after 48 valid bits.
REQ-038 Degenerate and misaligned inputs: an all-zero stream -> locked never asserts; a mismatch during VERIFY -> back to SEED, lock delayed accordingly.
REQ-039 Gaps and reset: in_valid toggled randomly -> same lock point counted in valid bits; rst pulsed mid-lock -> all outputs 0 asynchronously.
REQ-040 Counter boundaries: force 65535 errors -> error_count holds 16'hFFFF; err_clear coincident with an error -> error_count=1.
